// File: rtl/prior_encoder_pending_if.sv
// Request/offer bundle for prior_encoder_pending: request pulses in, indexed
// valid/ready offer out, plus pending-set and collision visibility.
interface prior_encoder_pending_if #(
  parameter int N = 8,
  parameter int W = $clog2(N)
);
  logic [N-1:0] D;
  logic         ready;
  logic [W-1:0] idx;
  logic         V;
  logic [N-1:0] pending;
  logic         collide;

  // master is the encoder; slave is the event source plus consumer
  modport master (input D, ready, output idx, V, pending, collide);
  modport slave  (output D, ready, input idx, V, pending, collide);
endinterface

// File: rtl/prior_encoder_pending.sv
// Registered N-input priority encoder with pending-event capture, fixed or
// round-robin arbitration and a valid/ready index offer.
module prior_encoder_pending #(
  parameter int N           = 8,
  parameter int W           = $clog2(N),
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  prior_encoder_pending_if.master bus
);

  logic [N-1:0] p_q;
  logic         v_q;
  logic [W-1:0] idx_q;
  logic [W-1:0] ptr_q;
  logic         collide_q;

  logic         accept;
  logic         slot_free;
  logic         load;
  logic         found;
  logic [W-1:0] pos;
  logic [W-1:0] sel;
  logic [N-1:0] clr;

  assign accept    = v_q & bus.ready;
  assign slot_free = ~v_q | accept;
  assign load      = slot_free & (|p_q);

  // Downward search starting just below ptr, wrapping N-1 after 0. In fixed
  // mode ptr never moves off 0, so the search is plain highest-bit-wins.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment; otherwise a path that skips it infers a latch.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = W'((int'(ptr_q) + 2 * N - 1 - k) % N);
      if (!found && p_q[pos]) begin
        sel   = pos;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    clr = '0;
    if (load) clr[sel] = 1'b1;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q       <= '0;
      v_q       <= 1'b0;
      idx_q     <= '0;
      ptr_q     <= '0;
      collide_q <= 1'b0;
    end else begin
      // A new pulse wins over the clear, so it survives as a fresh event.
      p_q       <= (p_q & ~clr) | bus.D;
      collide_q <= |(bus.D & p_q & ~clr);
      if (slot_free) begin
        v_q <= |p_q;
        if (load) begin
          idx_q <= sel;
          if (ROUND_ROBIN) ptr_q <= sel;
        end
      end
    end
  end

  assign bus.idx     = idx_q;
  assign bus.V       = v_q;
  assign bus.pending = p_q;
  assign bus.collide = collide_q;

endmodule

// File: tb/tb_prior_encoder_pending.sv
// Directed bench for prior_encoder_pending: fixed and round-robin instances,
// expected offers queued at stimulus time and checked by a handshake monitor.
module tb_prior_encoder_pending;
  localparam int N = 8;
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prior_encoder_pending_if #(.N(N), .W(W)) fx ();
  prior_encoder_pending_if #(.N(N), .W(W)) rr ();

  prior_encoder_pending #(.N(N), .W(W), .ROUND_ROBIN(1'b0)) u_fixed (
    .clk(clk), .rst(rst), .bus(fx)
  );
  prior_encoder_pending #(.N(N), .W(W), .ROUND_ROBIN(1'b1)) u_rr (
    .clk(clk), .rst(rst), .bus(rr)
  );

  int tests = 0;
  int fails = 0;
  int exp_fx[$];
  int exp_rr[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every accepted offer must match the head of its queue.
  always @(negedge clk) begin
    if (!rst && fx.V && fx.ready) begin
      if (exp_fx.size() == 0) begin
        tests++; fails++;
        $display("FAIL fx_unexpected_offer: got idx %0d expected no offer", fx.idx);
      end else check("fx_idx", 64'(fx.idx), 64'(exp_fx.pop_front()));
    end
    if (!rst && rr.V && rr.ready) begin
      if (exp_rr.size() == 0) begin
        tests++; fails++;
        $display("FAIL rr_unexpected_offer: got idx %0d expected no offer", rr.idx);
      end else check("rr_idx", 64'(rr.idx), 64'(exp_rr.pop_front()));
    end
  end

  task automatic drain(input string name);
    for (int c = 0; c < 40 && (exp_fx.size() != 0 || exp_rr.size() != 0 || fx.V || rr.V); c++)
      step();
    check({name, "_fx_left"}, 64'(exp_fx.size()), 64'd0);
    check({name, "_rr_left"}, 64'(exp_rr.size()), 64'd0);
  endtask

  initial begin
    int seq[4];
    seq = '{7, 5, 2, 1};
    rst = 1'b1;
    fx.D = '0; fx.ready = 1'b0;
    rr.D = '0; rr.ready = 1'b0;
    step(2);
    rst = 1'b0;
    check("rst_V", 64'(fx.V), 64'd0);
    check("rst_pending", 64'(fx.pending), 64'd0);
    check("rst_idx", 64'(fx.idx), 64'd0);
    check("rst_collide", 64'(fx.collide), 64'd0);
    check("rst_rr_V", 64'(rr.V), 64'd0);

    // 1: single pulse, two-cycle latency, one-cycle offer
    fx.ready = 1'b1;
    fx.D = 8'h20; exp_fx.push_back(5);
    step(); fx.D = '0;
    check("t1_pending", 64'(fx.pending), 64'h20);
    step();
    check("t1_V", 64'(fx.V), 64'd1);
    check("t1_idx", 64'(fx.idx), 64'd5);
    step();
    check("t1_V_drop", 64'(fx.V), 64'd0);
    check("t1_pending_empty", 64'(fx.pending), 64'd0);
    drain("t1");

    // 2: multi-bit burst drains highest first, back-to-back
    fx.D = 8'hA6;
    foreach (seq[k]) exp_fx.push_back(seq[k]);
    step(); fx.D = '0;
    step();
    for (int k = 0; k < 4; k++) begin
      check("t2_V", 64'(fx.V), 64'd1);
      check("t2_idx", 64'(fx.idx), 64'(seq[k]));
      step();
    end
    check("t2_V_drop", 64'(fx.V), 64'd0);
    drain("t2");

    // 3: stalled offer is not preempted by a higher request
    fx.ready = 1'b0;
    fx.D = 8'h02; exp_fx.push_back(1);
    step();
    fx.D = 8'h80; exp_fx.push_back(7);
    step(); fx.D = '0;
    check("t3_pending", 64'(fx.pending), 64'h80);
    for (int k = 0; k < 3; k++) begin
      check("t3_hold_V", 64'(fx.V), 64'd1);
      check("t3_hold_idx", 64'(fx.idx), 64'd1);
      step();
    end
    fx.ready = 1'b1;
    step(3);
    check("t3_V_drop", 64'(fx.V), 64'd0);
    check("t3_pending_empty", 64'(fx.pending), 64'd0);
    drain("t3");

    // 5: repeated request for an already-pending bit is merged and flagged
    fx.ready = 1'b0;
    fx.D = 8'h01; exp_fx.push_back(0);
    step(); fx.D = '0;
    step();
    fx.D = 8'h10; exp_fx.push_back(4);
    step();
    check("t5_collide_first", 64'(fx.collide), 64'd0);
    step(); fx.D = '0;
    check("t5_collide", 64'(fx.collide), 64'd1);
    step();
    check("t5_collide_pulse", 64'(fx.collide), 64'd0);
    fx.ready = 1'b1;
    step(3);
    check("t5_V_drop", 64'(fx.V), 64'd0);
    check("t5_pending_empty", 64'(fx.pending), 64'd0);
    drain("t5");

    // 4: round-robin with all requests held high
    rr.ready = 1'b1;
    for (int n = 0; n < 17; n++) exp_rr.push_back(7 - (n % 8));
    for (int c = 0; c < 10; c++) begin
      rr.D = 8'hFF;
      step();
      if (c == 0) check("t4_collide_first", 64'(rr.collide), 64'd0);
      if (c == 1) check("t4_collide", 64'(rr.collide), 64'd1);
      if (c == 9) check("t4_pending_full", 64'(rr.pending), 64'hFF);
    end
    rr.D = '0;
    step();
    check("t4_collide_end", 64'(rr.collide), 64'd0);
    drain("t4");

    // 6: reset mid-offer drops everything and ignores D
    fx.ready = 1'b0;
    fx.D = 8'h01;
    step();
    fx.D = 8'h0C;
    step(); fx.D = '0;
    check("t6_pre_V", 64'(fx.V), 64'd1);
    check("t6_pre_pending", 64'(fx.pending), 64'h0C);
    rst = 1'b1; fx.D = 8'hFF;
    step();
    rst = 1'b0; fx.D = '0;
    check("t6_V", 64'(fx.V), 64'd0);
    check("t6_pending", 64'(fx.pending), 64'd0);
    check("t6_idx", 64'(fx.idx), 64'd0);
    check("t6_collide", 64'(fx.collide), 64'd0);
    step();
    check("t6_idle_V", 64'(fx.V), 64'd0);
    fx.ready = 1'b1;
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
